// File: rtl/kled_pkg.sv
// Shared types and default constants for the kled_driver LED mode controller.
package kled_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

    localparam int unsigned DEF_CNT_SLOW   = 25_000_000;
    localparam int unsigned DEF_CNT_FAST   = 6_250_000;
    localparam int unsigned DEF_PWM_PERIOD = 1000;
    localparam int unsigned DUTY_W         = 11;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kled_if.sv
// Key-event handshake between the debouncer (master) and kled_driver (slave).
interface kled_if;
    logic       evt_valid;
    logic [1:0] evt_key;
    logic       evt_ready;

    modport master (output evt_valid, output evt_key, input evt_ready);
    modport slave  (input evt_valid, input evt_key, output evt_ready);
endinterface

// File: rtl/kled_timebase.sv
// Free-running 0..COUNT-1 counter with a wrap pulse and a phase that toggles on each wrap.
module kled_timebase
    import kled_pkg::*;
#(
    parameter int unsigned COUNT = 2,
    parameter int unsigned CW    = cnt_width(COUNT)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] cnt_o,
    output logic          phase_o,
    output logic          wrap_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign wrap_o = (cnt_q == CW'(COUNT - 1));

    // NOTE: combinational next-state gets every output assigned on every path, so no latch is inferred.
    always_comb begin
        cnt_d   = wrap_o ? '0 : cnt_q + CW'(1);
        phase_d = phase_q ^ wrap_o;
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/kled_driver.sv
// Four-LED mode controller: each key press cycles its LED through OFF/ON/SLOW/FAST.
// Define KLED_BREATH_EN to replace the FAST blink of mode 3 with PWM breathing.
module kled_driver
    import kled_pkg::*;
#(
    parameter int unsigned CNT_SLOW   = DEF_CNT_SLOW,
    parameter int unsigned CNT_FAST   = DEF_CNT_FAST,
    parameter int unsigned PWM_PERIOD = DEF_PWM_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    kled_if.slave      evt,
    output logic [3:0] led,
    output logic [7:0] mode
);

    localparam int unsigned SLOW_W = cnt_width(CNT_SLOW);
    localparam int unsigned FAST_W = cnt_width(CNT_FAST);

    if (CNT_SLOW < 1 || CNT_FAST < 1 || PWM_PERIOD < 2 || PWM_PERIOD > (1 << DUTY_W)) begin : g_bad_params
        $error("kled_driver: counts must be >= 1 and PWM_PERIOD within 2..2048");
    end

    state_e       state_q;
    logic [1:0]   key_q;
    logic         ready_q;
    mode_e [3:0]  mode_q;
    logic [3:0]   led_q, led_d;

    logic [SLOW_W-1:0] slow_cnt;
    logic [FAST_W-1:0] fast_cnt;
    logic              slow_phase, slow_wrap;
    logic              fast_phase, fast_wrap;
    logic              mode3_bit;

    kled_timebase #(.COUNT(CNT_SLOW)) u_slow (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_o   (slow_cnt),
        .phase_o (slow_phase),
        .wrap_o  (slow_wrap)
    );

    kled_timebase #(.COUNT(CNT_FAST)) u_fast (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_o   (fast_cnt),
        .phase_o (fast_phase),
        .wrap_o  (fast_wrap)
    );

`ifdef KLED_BREATH_EN
    localparam int unsigned          PWM_W    = cnt_width(PWM_PERIOD);
    localparam logic [DUTY_W-1:0]    DUTY_TOP = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0]    DUTY_ONE = DUTY_W'(1);

    logic [PWM_W-1:0]  pwm_cnt;
    logic              pwm_phase, pwm_wrap;
    logic [DUTY_W-1:0] duty_q;
    logic              falling_q;

    kled_timebase #(.COUNT(PWM_PERIOD)) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_o   (pwm_cnt),
        .phase_o (pwm_phase),
        .wrap_o  (pwm_wrap)
    );

    // Duty walks a triangle 0..PWM_PERIOD-1..0, one step per PWM frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q    <= '0;
            falling_q <= 1'b0;
        end else if (pwm_wrap) begin
            if (!falling_q && duty_q == DUTY_TOP) begin
                duty_q    <= duty_q - DUTY_ONE;
                falling_q <= 1'b1;
            end else if (falling_q && duty_q == '0) begin
                duty_q    <= duty_q + DUTY_ONE;
                falling_q <= 1'b0;
            end else if (falling_q) begin
                duty_q <= duty_q - DUTY_ONE;
            end else begin
                duty_q <= duty_q + DUTY_ONE;
            end
        end
    end

    assign mode3_bit = (DUTY_W'(pwm_cnt) < duty_q);

    logic unused_tb;
    assign unused_tb = ^{slow_cnt, slow_wrap, fast_cnt, fast_wrap, fast_phase, pwm_phase};
`else
    assign mode3_bit = fast_phase;

    logic unused_tb;
    assign unused_tb = ^{slow_cnt, slow_wrap, fast_cnt, fast_wrap};
`endif

    // Accept in IDLE, apply the increment in APPLY; ready is registered so it drops for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            key_q   <= 2'd0;
            mode_q  <= {4{MODE_OFF}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt.evt_valid && ready_q) begin
                        key_q   <= evt.evt_key;
                        ready_q <= 1'b0;
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    mode_q[key_q] <= mode_e'(mode_q[key_q] + 2'd1);
                    ready_q       <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < 4; i++) begin
            case (mode_q[i])
                MODE_OFF:  led_d[i] = 1'b0;
                MODE_ON:   led_d[i] = 1'b1;
                MODE_SLOW: led_d[i] = slow_phase;
                MODE_FAST: led_d[i] = mode3_bit;
                default:   led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign evt.evt_ready = ready_q;
    assign led           = led_q;
    assign mode          = mode_q;

endmodule

// File: tb/tb_kled_driver.sv
// Self-checking bench for kled_driver: cycle-by-cycle reference model plus directed literal checks.
module tb_kled_driver;

    localparam int unsigned T_SLOW = 8;
    localparam int unsigned T_FAST = 2;
    localparam int unsigned T_PWM  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] led;
    logic [7:0] mode;

    kled_if ifc ();

    kled_driver #(
        .CNT_SLOW   (T_SLOW),
        .CNT_FAST   (T_FAST),
        .PWM_PERIOD (T_PWM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (ifc),
        .led   (led),
        .mode  (mode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything is a function of the number of edges since reset release.
    int         k         = 0;
    logic [7:0] m_mode    = 8'h00;
    logic       m_ready   = 1'b1;
    logic       m_pending = 1'b0;
    logic [1:0] m_key     = 2'd0;
    logic [3:0] m_led     = 4'h0;
    logic       started   = 1'b0;

    function automatic int tri_duty(input int frame);
        int m;
        m = frame % (2 * (T_PWM - 1));
        return (m <= int'(T_PWM) - 1) ? m : 2 * (int'(T_PWM) - 1) - m;
    endfunction

    function automatic logic [3:0] exp_led(input logic [7:0] m, input int edges);
        logic [3:0] r;
        logic [1:0] f;
        r = 4'h0;
        for (int i = 0; i < 4; i++) begin
            f = m[2*i +: 2];
            case (f)
                2'd0: r[i] = 1'b0;
                2'd1: r[i] = 1'b1;
                2'd2: r[i] = ((edges / T_SLOW) % 2) == 1;
`ifdef KLED_BREATH_EN
                2'd3: r[i] = (edges % T_PWM) < tri_duty(edges / T_PWM);
`else
                2'd3: r[i] = ((edges / T_FAST) % 2) == 1;
`endif
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    // An accepted event bumps its LED's mode on the following edge; ready is low in between.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= 0;
            m_mode    <= 8'h00;
            m_ready   <= 1'b1;
            m_pending <= 1'b0;
            m_key     <= 2'd0;
            m_led     <= 4'h0;
        end else begin
            k     <= k + 1;
            m_led <= exp_led(m_mode, k);
            if (m_pending) begin
                m_mode[2*m_key +: 2] <= m_mode[2*m_key +: 2] + 2'd1;
                m_pending            <= 1'b0;
                m_ready              <= 1'b1;
            end else if (ifc.evt_valid) begin
                m_key     <= ifc.evt_key;
                m_pending <= 1'b1;
                m_ready   <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_led", {28'd0, led}, {28'd0, m_led});
            check("model_mode", {24'd0, mode}, {24'd0, m_mode});
            check("model_ready", {31'd0, ifc.evt_ready}, {31'd0, m_ready});
        end
    end

    task automatic send_event(input logic [1:0] key);
        @(negedge clk);
        ifc.evt_valid = 1'b1;
        ifc.evt_key   = key;
        @(negedge clk);
        ifc.evt_valid = 1'b0;
    endtask

    task automatic count_toggles(input int intervals, output int toggles);
        logic prev;
        toggles = 0;
        prev    = led[0];
        for (int i = 0; i < intervals; i++) begin
            @(negedge clk);
            if (led[0] != prev) toggles++;
            prev = led[0];
        end
    endtask

    task automatic frame_lit(output int lit);
        lit = 0;
        for (int i = 0; i < int'(T_PWM); i++) begin
            @(negedge clk);
            lit += int'(led[3]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tog;
        int acc;
        int lit;
        logic found;
        int exp_seq [6];
        exp_seq = '{1, 2, 3, 2, 1, 0};

        rst_n         = 1'b0;
        ifc.evt_valid = 1'b0;
        ifc.evt_key   = 2'd0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        started = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_led", {28'd0, led}, 32'h0);
        check("reset_mode", {24'd0, mode}, 32'h00);
        check("reset_ready", {31'd0, ifc.evt_ready}, 32'h1);

        // Single event on key 2: ready low in N+1, mode at N+1 end, led at N+2 end
        send_event(2'd2);
        check("single_ready_low", {31'd0, ifc.evt_ready}, 32'h0);
        check("single_mode_pending", {24'd0, mode}, 32'h00);
        @(negedge clk);
        check("single_mode", {24'd0, mode}, 32'h10);
        check("single_ready_back", {31'd0, ifc.evt_ready}, 32'h1);
        check("single_led_pending", {28'd0, led}, 32'h0);
        @(negedge clk);
        check("single_led", {28'd0, led}, 32'h4);

        // Wrap through all four modes on key 0
        send_event(2'd0);
        @(negedge clk);
        check("wrap_mode1", {30'd0, mode[1:0]}, 32'd1);
        send_event(2'd0);
        @(negedge clk);
        check("wrap_mode2", {30'd0, mode[1:0]}, 32'd2);
        repeat (2) @(negedge clk);
        count_toggles(32, tog);
        check("slow_toggles_32", tog, 32'd4);
        send_event(2'd0);
        @(negedge clk);
        check("wrap_mode3", {30'd0, mode[1:0]}, 32'd3);
`ifndef KLED_BREATH_EN
        repeat (2) @(negedge clk);
        count_toggles(16, tog);
        check("fast_toggles_16", tog, 32'd8);
`endif
        send_event(2'd0);
        @(negedge clk);
        check("wrap_mode0", {30'd0, mode[1:0]}, 32'd0);
        check("wrap_other_fields", {24'd0, mode}, 32'h10);

        // Back-to-back: valid held for 6 cycles on key 1
        @(negedge clk);
        ifc.evt_valid = 1'b1;
        ifc.evt_key   = 2'd1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifc.evt_valid && ifc.evt_ready) acc++;
            @(negedge clk);
        end
        ifc.evt_valid = 1'b0;
        check("b2b_accepts", acc, 32'd3);
        check("b2b_mode_key1", {30'd0, mode[3:2]}, 32'd3);
        @(negedge clk);
        check("b2b_mode", {24'd0, mode}, 32'h1C);

        // Reset asserted while an event sits in APPLY
        @(negedge clk);
        ifc.evt_valid = 1'b1;
        ifc.evt_key   = 2'd3;
        @(posedge clk);
        #2;
        ifc.evt_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("midrst_ready", {31'd0, ifc.evt_ready}, 32'h1);
        check("midrst_mode", {24'd0, mode}, 32'h00);
        check("midrst_led", {28'd0, led}, 32'h0);
        repeat (2) @(negedge clk);

        // Release reset with an event already offered: taken on the first edge
        rst_n         = 1'b1;
        ifc.evt_valid = 1'b1;
        ifc.evt_key   = 2'd0;
        @(negedge clk);
        ifc.evt_valid = 1'b0;
        check("post_rst_accept", {31'd0, ifc.evt_ready}, 32'h0);
        @(negedge clk);
        check("post_rst_mode", {24'd0, mode}, 32'h01);
        check("post_rst_no_apply", {30'd0, mode[7:6]}, 32'd0);

`ifdef KLED_BREATH_EN
        // Breathing on key 3: lit cycles per frame follow 0,1,2,3,2,1,0
        repeat (3) send_event(2'd3);
        repeat (2) @(negedge clk);
        check("breath_mode3", {30'd0, mode[7:6]}, 32'd3);
        for (int i = 0; i < 4 && (k % int'(T_PWM)) != 0; i++) @(negedge clk);
        found = 1'b0;
        for (int f = 0; f < 8 && !found; f++) begin
            frame_lit(lit);
            if (lit == 0) found = 1'b1;
        end
        check("breath_zero_frame", {31'd0, found}, 32'h1);
        for (int j = 0; j < 6; j++) begin
            frame_lit(lit);
            check($sformatf("breath_frame%0d", j), lit, exp_seq[j]);
        end
`endif

        repeat (4) @(negedge clk);
        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/kled_driver.md
KLED_DRIVER -- requirements
Module: kled_driver

Interface
REQ-001 SHALL have parameter CNT_SLOW, default 25_000_000: clk cycles per slow-blink half-period.
REQ-002 SHALL have parameter CNT_FAST, default 6_250_000: clk cycles per fast-blink half-period.
REQ-003 SHALL have parameter PWM_PERIOD, default 1000: clk cycles per breathing PWM frame; used only with KLED_BREATH_EN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port evt_valid, input, 1 bit: a debounced key-press event is offered.
REQ-007 SHALL have port evt_key, input, 2 bits: index (0-3) of the pressed key.
REQ-008 SHALL have port evt_ready, output, 1 bit: the block can accept an event.
REQ-009 SHALL have port led, output, 4 bits: registered LED drive, 1 = lit.
REQ-010 SHALL have port mode, output, 8 bits: current mode of LED i on bits [2i+1:2i].

Function
REQ-011 SHALL run a 2-state FSM: IDLE and APPLY.
REQ-012 SHALL drive evt_ready high in IDLE and low in APPLY.
REQ-013 SHALL accept an event only on a cycle where evt_valid and evt_ready are both high, latch evt_key, and enter APPLY.
REQ-014 SHALL, in APPLY, increment mode of the latched key modulo 4 (3 wraps to 0) and return to IDLE.
- Maximum throughput: one event per 2 cycles.
- evt_valid held high is accepted again on the next IDLE cycle.
REQ-015 SHALL ignore evt_key and evt_valid while in APPLY.
REQ-016 SHALL map each 2-bit mode value as follows:
- 0 = OFF: led 0.
- 1 = ON: led 1.
- 2 = SLOW: led follows slow_phase.
- 3 = FAST: led follows fast_phase.
REQ-017 SHALL generate slow_phase with a free-running counter over 0..CNT_SLOW-1 that toggles the phase on wrap; fast_phase is generated the same way from CNT_FAST.
REQ-018 SHALL NOT reset or realign the counters on a mode change.
REQ-019 SHALL register led with the following latency:
- Event accepted in cycle N.
- mode updated at the end of N+1.
- led reflects the new mode at the end of N+2.
REQ-020 SHALL update the mode field of the addressed LED only; the other three are unchanged.

Reset
REQ-021 SHALL, while rst_n is low, force the following asynchronously:
- FSM to IDLE.
- evt_ready = 1.
- mode = 8'h00.
- led = 4'h0.
- All counters and phases to 0.
REQ-022 SHALL discard any event in APPLY when reset asserts; the mode is not updated.
REQ-023 SHALL accept an event on the first clock edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with macro KLED_BREATH_EN defined, replace FAST in mode 3 with breathing:
- PWM counter runs over 0..PWM_PERIOD-1.
- An 11-bit duty steps by 1 per PWM frame, rising from 0 to PWM_PERIOD-1, then falling to 0, repeating.
- led = (pwm_cnt < duty).
- Duty and direction reset to 0/rising.
REQ-025 SHALL, without KLED_BREATH_EN, implement mode 3 as FAST blink and build no PWM logic.

Structure
REQ-026 SHALL take the following from a shared package kled_pkg:
- The mode encoding (OFF/ON/SLOW/FAST).
- The FSM state type.
- The default CNT_SLOW/CNT_FAST/PWM_PERIOD constants.
REQ-027 SHALL instantiate a sub-module kled_timebase (parameterised count, outputs phase and wrap pulse) twice: slow and fast; it is reused for the PWM frame tick.

Verification
REQ-028 SHALL be verified with CNT_SLOW=8, CNT_FAST=2, PWM_PERIOD=4 and these scenarios:
- Reset: after rst_n deassert -> led=4'h0, mode=8'h00, evt_ready=1.
- Single event: evt_valid pulse with evt_key=2 -> mode=8'h10 at N+1, led[2]=1 at N+2, evt_ready low exactly in cycle N+1.
- Wrap: 4 events on key 0 -> mode[1:0] sequence 1,2,3,0; led[0] toggles every 8 cycles in SLOW and every 2 cycles in FAST.
- Back-to-back: evt_valid held high for 6 cycles with key 1 -> exactly 3 acceptances, mode[3:2]=3.
- Mid-operation reset: rst_n pulled low during APPLY -> mode stays 8'h00, evt_ready=1 immediately.
- KLED_BREATH_EN build: key 3 set to mode 3 -> lit cycles per 4-cycle frame step 0,1,2,3,2,1,0.
